// File: rtl/image_stage_sequencer_if.sv
// Stage-side and SRAM-side buses of image_stage_sequencer.
// master = sequencer, slave = stages plus frame SRAM.
interface image_stage_sequencer_if #(
    parameter int unsigned NUM_STAGES = 4
);
    logic [NUM_STAGES-1:0]    stage_done;
    logic [NUM_STAGES-1:0]    stage_wren;
    logic [18*NUM_STAGES-1:0] stage_address;
    logic [32*NUM_STAGES-1:0] stage_data_write;
    logic [NUM_STAGES-1:0]    stage_enable;
    logic                     sram_wren;
    logic [17:0]              sram_address;
    logic [31:0]              sram_data_write;

    modport master (
        input  stage_done, stage_wren, stage_address, stage_data_write,
        output stage_enable, sram_wren, sram_address, sram_data_write
    );

    modport slave (
        output stage_done, stage_wren, stage_address, stage_data_write,
        input  stage_enable, sram_wren, sram_address, sram_data_write
    );
endinterface

// File: rtl/image_stage_sequencer.sv
// Runs the selected image stages one at a time in index order on the shared frame SRAM.
// Optional per-stage watchdog is built when STAGE_WATCHDOG_EN is defined.
module image_stage_sequencer #(
    parameter int unsigned NUM_STAGES      = 4,
    parameter int unsigned WATCHDOG_CYCLES = 16000000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    pause,
    input  logic                    start,
    input  logic [NUM_STAGES-1:0]   stage_mask,
    image_stage_sequencer_if.master bus,
    output logic                    busy,
    output logic                    all_done,
    output logic [2:0]              current_stage,
    output logic [NUM_STAGES-1:0]   stage_timeout
);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        RUN,
        RELEASE,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [NUM_STAGES-1:0] mask_q, mask_d;
    logic [3:0]            ptr_q, ptr_d;
    logic [2:0]            cur_q, cur_d;

    logic                  found;
    logic [2:0]            found_idx;
    logic                  cur_done;
    logic                  cur_wren;
    logic [17:0]           cur_addr;
    logic [31:0]           cur_data;
    logic                  expire;

    // Lowest latched stage at or above the search pointer.
    always_comb begin
        found     = 1'b0;
        found_idx = '0;
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            if (!found && (i >= 32'(ptr_q)) && mask_q[i]) begin
                found     = 1'b1;
                found_idx = 3'(i);
            end
        end
    end

    always_comb begin
        cur_done = 1'b0;
        cur_wren = 1'b0;
        cur_addr = '0;
        cur_data = '0;
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            if (32'(cur_q) == i) begin
                cur_done = bus.stage_done[i];
                cur_wren = bus.stage_wren[i];
                cur_addr = bus.stage_address[18*i +: 18];
                cur_data = bus.stage_data_write[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        ptr_d   = ptr_q;
        cur_d   = cur_q;
        if (!pause) begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        mask_d  = stage_mask;
                        ptr_d   = '0;
                        state_d = SELECT;
                    end
                end
                SELECT: begin
                    if (found) begin
                        cur_d   = found_idx;
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end
                RUN: begin
                    if (cur_done || expire) begin
                        state_d = RELEASE;
                    end
                end
                RELEASE: begin
                    ptr_d   = 4'(cur_q) + 4'd1;
                    state_d = SELECT;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            mask_q  <= '0;
            ptr_q   <= '0;
            cur_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            ptr_q   <= ptr_d;
            cur_q   <= cur_d;
        end
    end

    // SRAM port follows the running stage with no added latency; writes are masked while frozen.
    always_comb begin
        bus.stage_enable    = '0;
        bus.sram_wren       = 1'b0;
        bus.sram_address    = '0;
        bus.sram_data_write = '0;
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            bus.stage_enable[i] = (state_q == RUN) && (32'(cur_q) == i);
        end
        if (state_q == RUN) begin
            bus.sram_wren       = cur_wren & ~pause;
            bus.sram_address    = cur_addr;
            bus.sram_data_write = cur_data;
        end
    end

    assign busy          = (state_q != IDLE);
    assign all_done      = (state_q == DONE);
    assign current_stage = cur_q;

`ifdef STAGE_WATCHDOG_EN
    logic [31:0]           wd_q, wd_d;
    logic [NUM_STAGES-1:0] to_q, to_d;

    assign expire = (wd_q == 32'(WATCHDOG_CYCLES - 1));

    // A done seen on the expiry cycle takes precedence, so no flag is raised then.
    always_comb begin
        wd_d = wd_q;
        to_d = to_q;
        if (!pause) begin
            if ((state_q == IDLE) && start) begin
                to_d = '0;
            end
            if (state_q == SELECT) begin
                wd_d = '0;
            end else if (state_q == RUN) begin
                wd_d = wd_q + 32'd1;
                if (!cur_done && expire) begin
                    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
                        if (32'(cur_q) == i) begin
                            to_d[i] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wd_q <= '0;
            to_q <= '0;
        end else begin
            wd_q <= wd_d;
            to_q <= to_d;
        end
    end

    assign stage_timeout = to_q;
`else
    assign expire        = 1'b0;
    assign stage_timeout = '0;

    // Watchdog limit has no effect in this build.
    if (WATCHDOG_CYCLES == 0) begin : g_wd_limit_unused
    end
`endif

endmodule

// File: tb/tb_image_stage_sequencer.sv
// Self-checking bench for image_stage_sequencer: directed timing scenarios plus randomized
// passes checked against a cycle-slot schedule derived from per-stage run lengths.
module tb_image_stage_sequencer;

    localparam int unsigned NS = 4;
    localparam int unsigned WD = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          pause;
    logic          start;
    logic [NS-1:0] stage_mask;
    logic          busy;
    logic          all_done;
    logic [2:0]    current_stage;
    logic [NS-1:0] stage_timeout;

    int            checks = 0;
    int            errors = 0;
    logic [2:0]    m_cur  = '0;

    image_stage_sequencer_if #(.NUM_STAGES(NS)) bus ();

    image_stage_sequencer #(
        .NUM_STAGES      (NS),
        .WATCHDOG_CYCLES (WD)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pause         (pause),
        .start         (start),
        .stage_mask    (stage_mask),
        .bus           (bus),
        .busy          (busy),
        .all_done      (all_done),
        .current_stage (current_stage),
        .stage_timeout (stage_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NS-1:0] en;
        logic          busy;
        logic          ad;
        logic [2:0]    cur;
        int            stage;
        logic          fin;
    } slot_t;

    task automatic noise();
        bus.stage_wren = NS'($urandom);
        for (int unsigned i = 0; i < NS; i++) begin
            bus.stage_address[18*i +: 18]    = 18'($urandom);
            bus.stage_data_write[32*i +: 32] = $urandom;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; pause = 1'b0; start = 1'b0; stage_mask = '0;
        bus.stage_done = '0;
        noise();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, all_done, current_stage, stage_timeout, bus.stage_enable, bus.sram_wren,
             bus.sram_address, bus.sram_data_write} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b cur=%0d to=%b en=%b wr=%b a=%h d=%h want all 0",
                     busy, all_done, current_stage, stage_timeout, bus.stage_enable,
                     bus.sram_wren, bus.sram_address, bus.sram_data_write);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            stage_mask = NS'($urandom);
            bus.stage_done = NS'($urandom);
            noise();
            @(negedge clk);
            checks++;
            if ({busy, bus.stage_enable, bus.sram_wren, bus.sram_address} !== '0) begin
                errors++;
                $display("FAIL idle_quiet cyc %0d: got busy=%b en=%b wr=%b a=%h want 0", c,
                         busy, bus.stage_enable, bus.sram_wren, bus.sram_address);
            end
        end
        m_cur = '0;
    endtask

    // mask 0101, start at c=0, stage 0 done at c=20, stage 2 done at c=40.
    task automatic test_directed_0101();
        logic [NS-1:0] exp_en;
        for (int c = 0; c <= 45; c++) begin
            @(posedge clk); #1;
            start = (c == 0);
            stage_mask = (c == 0) ? 4'b0101 : NS'($urandom);
            pause = 1'b0;
            bus.stage_done[0] = (c == 20);
            bus.stage_done[1] = 1'($urandom_range(0, 1));
            bus.stage_done[2] = (c == 40);
            bus.stage_done[3] = 1'($urandom_range(0, 1));
            noise();
            #2;
            exp_en = (c >= 2 && c <= 20) ? 4'b0001 : (c >= 23 && c <= 40) ? 4'b0100 : 4'b0000;
            checks++;
            if (bus.stage_enable !== exp_en) begin
                errors++;
                $display("FAIL dir_enable c=%0d: got %b want %b", c, bus.stage_enable, exp_en);
            end
            checks++;
            if (all_done !== (c == 43)) begin
                errors++;
                $display("FAIL dir_all_done c=%0d: got %b want %b", c, all_done, (c == 43));
            end
            checks++;
            if (busy !== (c >= 1 && c <= 43)) begin
                errors++;
                $display("FAIL dir_busy c=%0d: got %b want %b", c, busy, (c >= 1 && c <= 43));
            end
            checks++;
            if (current_stage !== ((c >= 23) ? 3'd2 : 3'd0)) begin
                errors++;
                $display("FAIL dir_cur c=%0d: got %0d want %0d", c, current_stage, (c >= 23) ? 2 : 0);
            end
        end
        m_cur = 3'd2;
    endtask

    task automatic test_mux();
        logic        ew;
        logic [17:0] ea;
        logic [31:0] ed;
        for (int c = 0; c <= 8; c++) begin
            @(posedge clk); #1;
            start = (c == 0);
            stage_mask = 4'b0001;
            pause = 1'b0;
            bus.stage_done = (c == 4) ? 4'b0001 : 4'b0000;
            bus.stage_wren = '0;
            bus.stage_address = '0;
            bus.stage_data_write = '0;
            ew = 1'b0; ea = '0; ed = '0;
            if (c == 2) begin
                bus.stage_wren[0] = 1'b1;
                bus.stage_address[17:0] = 18'h12345;
                bus.stage_data_write[31:0] = 32'hA5A5A5A5;
                ew = 1'b1; ea = 18'h12345; ed = 32'hA5A5A5A5;
            end else if (c == 3) begin
                bus.stage_wren[1] = 1'b1;
                bus.stage_address[35:18] = 18'h12345;
                bus.stage_data_write[63:32] = 32'hA5A5A5A5;
                bus.stage_address[17:0] = 18'h00ABC;
                ea = 18'h00ABC;
            end else if (c == 5) begin
                bus.stage_wren[0] = 1'b1;
                bus.stage_address[17:0] = 18'h3FFFF;
                bus.stage_data_write[31:0] = 32'hFFFFFFFF;
            end
            #2;
            if (c == 2 || c == 3 || c == 5) begin
                checks++;
                if ({bus.sram_wren, bus.sram_address, bus.sram_data_write} !== {ew, ea, ed}) begin
                    errors++;
                    $display("FAIL mux c=%0d: got wr=%b a=%h d=%h want wr=%b a=%h d=%h", c,
                             bus.sram_wren, bus.sram_address, bus.sram_data_write, ew, ea, ed);
                end
            end
        end
        m_cur = 3'd0;
    endtask

    // Expected behaviour as a list of unpaused cycle slots; a paused cycle repeats its slot.
    task automatic run_pass(input logic [NS-1:0] mask, input int unsigned pprob, input string tag);
        slot_t         q[$];
        slot_t         s;
        int            idx;
        int            guard;
        int unsigned   len;
        logic          ew;
        logic [17:0]   ea;
        logic [31:0]   ed;
        s = '{en: '0, busy: 1'b0, ad: 1'b0, cur: m_cur, stage: -1, fin: 1'b0};
        q.push_back(s);
        s.busy = 1'b1;
        q.push_back(s);
        for (int k = 0; k < int'(NS); k++) begin
            if (mask[k]) begin
                len = $urandom_range(1, 6);
                for (int unsigned j = 1; j <= len; j++) begin
                    s.en = NS'(1) << k; s.cur = 3'(k); s.stage = k; s.fin = (j == len);
                    q.push_back(s);
                end
                s.en = '0; s.stage = -1; s.fin = 1'b0;
                q.push_back(s);
                q.push_back(s);
            end
        end
        s.ad = 1'b1;
        q.push_back(s);
        s.ad = 1'b0; s.busy = 1'b0;
        q.push_back(s);
        m_cur = s.cur;

        idx = 0;
        guard = 0;
        while (idx < q.size() && guard < 2000) begin
            @(posedge clk); #1;
            guard++;
            s = q[idx];
            pause = (idx == 0) ? 1'b0 : ($urandom_range(0, 99) < pprob);
            start = (idx == 0) ? 1'b1 : (idx == q.size() - 1) ? 1'b0 : 1'($urandom_range(0, 1));
            stage_mask = (idx == 0) ? mask : NS'($urandom);
            for (int unsigned i = 0; i < NS; i++) begin
                bus.stage_done[i] = (int'(i) == s.stage) ? s.fin : 1'($urandom_range(0, 1));
            end
            noise();
            ew = 1'b0; ea = '0; ed = '0;
            if (s.stage >= 0) begin
                ew = bus.stage_wren[s.stage] & ~pause;
                ea = bus.stage_address[18*s.stage +: 18];
                ed = bus.stage_data_write[32*s.stage +: 32];
            end
            #2;
            checks++;
            if (bus.stage_enable !== s.en) begin
                errors++;
                $display("FAIL %s_enable slot %0d: got %b want %b", tag, idx, bus.stage_enable, s.en);
            end
            checks++;
            if ({busy, all_done, current_stage} !== {s.busy, s.ad, s.cur}) begin
                errors++;
                $display("FAIL %s_status slot %0d: got busy=%b done=%b cur=%0d want busy=%b done=%b cur=%0d",
                         tag, idx, busy, all_done, current_stage, s.busy, s.ad, s.cur);
            end
            checks++;
            if ({bus.sram_wren, bus.sram_address, bus.sram_data_write} !== {ew, ea, ed}) begin
                errors++;
                $display("FAIL %s_sram slot %0d: got wr=%b a=%h d=%h want wr=%b a=%h d=%h", tag, idx,
                         bus.sram_wren, bus.sram_address, bus.sram_data_write, ew, ea, ed);
            end
            checks++;
            if (stage_timeout !== '0) begin
                errors++;
                $display("FAIL %s_timeout slot %0d: got %b want 0", tag, idx, stage_timeout);
            end
            if (!pause) idx++;
        end
        checks++;
        if (idx != q.size()) begin
            errors++;
            $display("FAIL %s_budget: reached slot %0d want %0d", tag, idx, q.size());
        end
        pause = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_pause();
        run_pass(4'b1111, 40, "pause_all");
        run_pass(NS'($urandom), 30, "pause_rand");
    endtask

    task automatic test_back_to_back();
        run_pass(4'b0000, 0, "b2b_empty");
        run_pass(4'b1000, 0, "b2b_last");
        for (int n = 0; n < 8; n++) begin
            run_pass(NS'($urandom), (n % 2 == 0) ? 0 : 10, "b2b_rand");
        end
    endtask

    task automatic test_reset_mid_run();
        for (int c = 0; c <= 5; c++) begin
            @(posedge clk); #1;
            start = (c == 0);
            stage_mask = 4'b0100;
            pause = 1'b0;
            bus.stage_done = 4'b1011 & NS'($urandom);
            noise();
            reset_n = !(c == 3 || c == 4);
            #2;
            if (c == 2 || c == 3) begin
                checks++;
                if (bus.stage_enable !== 4'b0100 || current_stage !== 3'd2) begin
                    errors++;
                    $display("FAIL rst_run_pre c=%0d: got en=%b cur=%0d want en=0100 cur=2", c,
                             bus.stage_enable, current_stage);
                end
            end
            if (c == 4) begin
                checks++;
                if ({bus.stage_enable, busy, current_stage} !== '0) begin
                    errors++;
                    $display("FAIL rst_run_post: got en=%b busy=%b cur=%0d want all 0",
                             bus.stage_enable, busy, current_stage);
                end
            end
        end
        m_cur = 3'd0;
    endtask

`ifdef STAGE_WATCHDOG_EN
    // mask 0011, stage 0 done at c=4, stage 1 never done: expires after WD run cycles.
    task automatic test_watchdog();
        logic [NS-1:0] exp_en;
        logic [NS-1:0] exp_to;
        for (int c = 0; c <= 19; c++) begin
            @(posedge clk); #1;
            start = (c == 0);
            stage_mask = 4'b0011;
            pause = 1'b0;
            bus.stage_done[0] = (c == 4);
            bus.stage_done[1] = 1'b0;
            bus.stage_done[2] = 1'($urandom_range(0, 1));
            bus.stage_done[3] = 1'($urandom_range(0, 1));
            noise();
            #2;
            exp_en = (c >= 2 && c <= 4) ? 4'b0001 :
                     (c >= 7 && c <= 7 + int'(WD) - 1) ? 4'b0010 : 4'b0000;
            exp_to = (c >= 7 + int'(WD)) ? 4'b0010 : 4'b0000;
            checks++;
            if (bus.stage_enable !== exp_en || stage_timeout !== exp_to) begin
                errors++;
                $display("FAIL wd c=%0d: got en=%b to=%b want en=%b to=%b", c,
                         bus.stage_enable, stage_timeout, exp_en, exp_to);
            end
            checks++;
            if (all_done !== (c == 7 + int'(WD) + 2)) begin
                errors++;
                $display("FAIL wd_all_done c=%0d: got %b want %b", c, all_done, (c == 7 + int'(WD) + 2));
            end
        end
    endtask
`endif

    initial begin
        #5000000;
        $display("FAIL global_time_limit: simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed_0101();
        test_mux();
        test_pause();
        test_back_to_back();
        test_reset_mid_run();
`ifdef STAGE_WATCHDOG_EN
        test_watchdog();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
